ifu_prefetch: RTL and testbench
===============================

Name: ifu_prefetch

Overview:
- Next-generation instruction fetch unit. Replaces the fixed single-cycle fetch with a handshaked, variable-latency memory interface and a parametrised prefetch queue.
- Sits between the PC/redirect logic and the decoder:
  - issues sequential fetch requests ahead of consumption;
  - buffers returned instructions together with their PCs;
  - hands them to the IDU over valid/ready;
  - flushes the queue on a control-flow redirect.

Parameters:
- XLEN, 32, address/PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored and treated as 0.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts the request.
- req_addr  out  XLEN  fetch address.
- resp_valid  in  1  read data valid for the single accepted, outstanding request; no backpressure.
- resp_data  in  ILEN  instruction word.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  IDU consumes the head.
- inst  out  ILEN  head instruction.
- inst_pc  out  XLEN  PC of the head instruction.

Behaviour:
- Reset (rst high at an edge):
  - fpc = RESET_PC; queue count = 0; read/write pointers = 0; state = IDLE.
  - While rst is high, req_valid = 0 and inst_valid = 0.
  - Reset mid-transaction: any in-flight response arriving after reset deasserts is ignored, because state is IDLE.
- Fire rules: request fire = req_valid & req_ready; pop = inst_valid & inst_ready.
- At most one outstanding request.
- Response latency is at least 1 cycle after request fire; any number of cycles is allowed.
- FSM states:
  - IDLE: nothing outstanding.
  - WAIT: outstanding; the response will be kept.
  - DROP: outstanding; the response will be discarded.
- Transitions (redirect has top priority):
  - IDLE: redirect -> IDLE; request fire -> WAIT.
  - WAIT:
    - resp_valid & redirect -> IDLE; the response is discarded.
    - redirect without resp_valid -> DROP.
    - resp_valid without redirect -> push {fpc_of_req, resp_data}; next state is WAIT if a new request fires this cycle, else IDLE.
  - DROP:
    - resp_valid -> discard the response; next state is WAIT if a request fires this cycle, else IDLE.
    - redirect without resp_valid -> stay in DROP.
- Request issue (combinational):
  - req_valid = !rst & !redirect_valid & (state==IDLE | resp_valid) & (count + pending < DEPTH).
  - pending = 1 if state==WAIT, else 0.
  - Pops in the same cycle are not credited, so the queue can never overflow.
- Address path:
  - req_addr = fpc.
  - On request fire: fpc += 4 (wraps modulo 2^XLEN); the address of the outstanding request is stored for its response.
  - On redirect: fpc = {redirect_pc[XLEN-1:2], 2'b00}; this overrides the increment.
- Request handshake:
  - req_valid/req_addr hold while stalled by !req_ready.
  - Exception: a redirect may withdraw the request or change the address; the memory side must only act on a fire.
- Queue:
  - Circular buffer of DEPTH entries {pc, inst}.
  - inst_valid = (count != 0); inst and inst_pc come from the head, registered storage only, with no bypass from resp_data.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
- Redirect:
  - Next cycle: count = 0, pointers reset, inst_valid = 0.
  - A pop or push in the redirect cycle is discarded.
  - Fetch from the new address may begin in the cycle after the redirect.
- Minimum latency: with memory latency 1 and req_ready always high:
  - first req_valid in the first cycle after reset deasserts;
  - inst_valid 2 cycles after reset deasserts;
  - steady state of 1 instruction per cycle.

Test Plan:
- Reset release, memory latency 1, req_ready=1, inst_ready=1 -> requests to 0x80000000, 0x80000004, 0x80000008, …; inst_pc sequence matches; first inst_valid 2 cycles after reset deasserts.
- inst_ready=0, DEPTH=4 -> exactly 4 request fires, then req_valid=0; raise inst_ready -> entries drain in order with the correct {pc, inst} pairs, and fetch resumes at 0x80000010.
- Request fired, memory latency 5, redirect to 0x80000102 at cycle 2 -> FSM enters DROP, the late response is not enqueued, next req_addr = 0x80000100, and the queue is empty in the cycle after the redirect.
- resp_valid and redirect_valid in the same cycle -> response discarded, state IDLE, next request at the redirect target.
- req_ready held 0 for 3 cycles -> req_addr stable at 0x80000000 and fpc not incremented until the fire.
- Assert rst while a request is outstanding with 3 entries queued -> inst_valid=0 and req_valid=0 during reset; after release, the stale response is ignored and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a single-outstanding, variable-latency memory port
// and a circular prefetch queue of {pc, inst} pairs feeding the decoder.
module ifu_prefetch #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state_reg;
    logic [XLEN-1:0] fpc_reg;
    logic [XLEN-1:0] req_pc_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW:0]     count_reg;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [ILEN-1:0] inst_mem [DEPTH];

    logic            pending;
    logic [PW:0]     occupancy;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            unused_ok;

    assign unused_ok = ^redirect_pc[1:0];

    // A kept outstanding response already owns a queue slot; pops are not credited.
    assign pending   = (state_reg == WAIT);
    assign occupancy = count_reg + {{PW{1'b0}}, pending};
    assign req_valid = !rst && !redirect_valid
                       && ((state_reg == IDLE) || resp_valid)
                       && (occupancy < DEPTH_C);
    assign req_addr  = fpc_reg;
    assign req_fire  = req_valid && req_ready;

    assign inst_valid = !rst && (count_reg != '0);
    assign inst       = inst_mem[rd_ptr_reg];
    assign inst_pc    = pc_mem[rd_ptr_reg];

    assign pop  = inst_valid && inst_ready && !redirect_valid;
    assign push = (state_reg == WAIT) && resp_valid && !redirect_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= req_pc_reg;
            inst_mem[wr_ptr_reg] <= resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            fpc_reg    <= RESET_PC;
            req_pc_reg <= RESET_PC;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (redirect_valid) begin
                fpc_reg <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (req_fire) begin
                fpc_reg <= fpc_reg + XLEN'(4);
            end
            if (req_fire) begin
                req_pc_reg <= fpc_reg;
            end

            case (state_reg)
                IDLE: begin
                    if (!redirect_valid && req_fire) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        state_reg <= resp_valid ? IDLE : DROP;
                    end else if (resp_valid) begin
                        state_reg <= req_fire ? WAIT : IDLE;
                    end
                end
                DROP: begin
                    if (resp_valid) begin
                        state_reg <= req_fire ? WAIT : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (redirect_valid) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                if (push && !pop) begin
                    count_reg <= count_reg + (PW+1)'(1);
                end else if (pop && !push) begin
                    count_reg <= count_reg - (PW+1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: a latency-programmable memory model plus a queue-based
// reference of the expected request address stream and delivered {pc, inst} pairs.
module tb_ifu_prefetch;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, redirect_valid, req_ready, resp_valid, inst_ready;
    logic [31:0] redirect_pc, resp_data;
    logic        req_valid, inst_valid;
    logic [31:0] req_addr, inst, inst_pc;

    always #5 clk = ~clk;

    ifu_prefetch #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: expected queue contents, next fetch address, and
    // whether an outstanding response is still wanted by the fetch unit.
    logic [63:0] q[$];
    logic [31:0] m_fpc = RESET_PC;
    logic [31:0] out_addr = '0;
    bit          busy = 0, keep = 0, mem_out = 0;
    int          lat_left = 0, lat = 1, fires = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                        input bit rr, input bit ir);
        bit exp_rv, exp_iv, fire, pop, push;
        rst = r; redirect_valid = redir; redirect_pc = rpc;
        req_ready = rr; inst_ready = ir;
        if (mem_out) lat_left--;
        resp_valid = mem_out && (lat_left == 0);
        resp_data  = resp_valid ? mem_word(out_addr) : $urandom;
        @(negedge clk);
        exp_rv = !r && !redir && (!busy || resp_valid)
                 && (q.size() + ((busy && keep) ? 1 : 0) < DEPTH);
        exp_iv = !r && (q.size() != 0);
        check(64'(req_valid), 64'(exp_rv), "req_valid");
        check(64'(inst_valid), 64'(exp_iv), "inst_valid");
        if (exp_rv) check(64'(req_addr), 64'(m_fpc), "req_addr");
        if (exp_iv) check({inst_pc, inst}, q[0], "head_pc_inst");
        $display("t=%0t rst=%0b redir=%0b req=%0b@%h resp=%0b inst=%0b pc=%h qsize=%0d",
                 $time, r, redir, req_valid, req_addr, resp_valid, inst_valid, inst_pc, q.size());
        fire = exp_rv && rr;
        pop  = exp_iv && ir;
        push = 0;
        if (resp_valid) begin
            mem_out = 0;
            if (busy) begin
                busy = 0;
                push = keep && !redir;
            end
        end
        if (r) begin
            q.delete(); m_fpc = RESET_PC; busy = 0; keep = 0;
        end else if (redir) begin
            q.delete(); m_fpc = {rpc[31:2], 2'b00}; keep = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({out_addr, mem_word(out_addr)});
            if (fire) begin
                out_addr = m_fpc; m_fpc = m_fpc + 32'd4;
                mem_out = 1; busy = 1; keep = 1; lat_left = lat; fires++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_fire(input string tag);
        int f0 = fires;
        for (int i = 0; i < 40 && fires == f0; i++) step(0, 0, 0, 1, 1);
        if (fires == f0) timeout(tag);
    endtask

    initial begin
        rst = 1; redirect_valid = 0; redirect_pc = '0; req_ready = 0;
        inst_ready = 0; resp_valid = 0; resp_data = '0;

        // Reset release, latency 1, full throughput.
        lat = 1;
        step(1, 0, 0, 1, 1); step(1, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);

        // Decoder stalled: queue fills to DEPTH, then drains in order.
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

        // Long-latency request redirected before its response returns.
        lat = 5;
        wait_fire("fire_lat5");
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h8000_0102, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

        // Response and redirect in the same cycle.
        lat = 2;
        wait_fire("fire_lat2");
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h8000_0200, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);

        // Memory stall: address must hold until the fire.
        lat = 1;
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);

        // Reset with three entries queued and one request in flight.
        lat = 3;
        step(1, 0, 0, 1, 0);
        begin
            int f0 = fires;
            for (int i = 0; i < 40 && fires - f0 < 4; i++) step(0, 0, 0, 1, 0);
            if (fires - f0 < 4) timeout("fill_before_reset");
        end
        step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 4);
            step(0, ($urandom % 16) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 4) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
